// File: rtl/mac_pkg.sv
// Shared types and widths for the Booth multiply-accumulate controller.
// MAC_SAT_EN selects saturating accumulation (limits below) instead of wrapping.
package mac_pkg;

  localparam int unsigned OP_W   = 16;
  localparam int unsigned PROD_W = 32;
  localparam int unsigned ACC_W  = 40;

  // Saturation limits of the signed accumulator
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    ACC       = 3'd4,
    OUT       = 3'd5
  } state_e;

endpackage

// File: rtl/mac_acc40.sv
// Combinational 40-bit accumulate step: sign-extends the product and adds it.
// With MAC_SAT_EN the sum clamps to the signed range and flags overflow.
module mac_acc40
  import mac_pkg::*;
(
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_c,
  output logic              ovf_c
);

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] raw;

  always_comb begin
    prod_ext = {{(ACC_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};
    raw      = acc_i + prod_ext;
    sum_c    = raw;
    ovf_c    = 1'b0;
`ifdef MAC_SAT_EN
    // Overflow only when both addends share a sign the result does not
    ovf_c = (acc_i[ACC_W-1] == prod_ext[ACC_W-1]) && (raw[ACC_W-1] != acc_i[ACC_W-1]);
    if (ovf_c) begin
      sum_c = acc_i[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
`else
    ovf_c = 1'b0;
`endif
  end

endmodule

// File: rtl/booth_mac_ctrl.sv
// Dot-product controller driving a sequential Booth multiplier and a 40-bit accumulator.
// Build option MAC_SAT_EN: saturating accumulate with sticky overflow (else wrap, out_ovf=0).
module booth_mac_ctrl
  import mac_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_x,
  input  logic [OP_W-1:0]   in_y,
  input  logic              in_last,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_x,
  output logic [OP_W-1:0]   mul_y,
  input  logic              mul_busy,
  input  logic [PROD_W-1:0] mul_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf
);

  state_e state_q, state_d;

  logic              in_ready_q, in_ready_d;
  logic              mul_start_q, mul_start_d;
  logic              out_valid_q, out_valid_d;
  logic [OP_W-1:0]   mul_x_q, mul_x_d;
  logic [OP_W-1:0]   mul_y_q, mul_y_d;
  logic              last_q, last_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [ACC_W-1:0]  sum_c;
  logic              ovf_c;
  logic              accept_c;

  assign accept_c = (state_q == IDLE) && in_valid && in_ready_q;

  mac_acc40 u_acc (
    .acc_i  (acc_q),
    .prod_i (mul_z),
    .sum_c  (sum_c),
    .ovf_c  (ovf_c)
  );

  // State register plus all registered outputs and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      mul_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      last_q      <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mul_start_q <= mul_start_d;
      out_valid_q <= out_valid_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept_c) state_d = START;
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (mul_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!mul_busy) state_d = ACC;
      ACC:       state_d = last_q ? OUT : IDLE;
      OUT:       if (out_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output and datapath next values; handshake outputs follow the upcoming state
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    mul_start_d = (state_d == START);
    out_valid_d = (state_d == OUT);
    mul_x_d     = mul_x_q;
    mul_y_d     = mul_y_q;
    last_d      = last_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          mul_x_d = in_x;
          mul_y_d = in_y;
          last_d  = in_last;
        end
      end
      ACC: begin
        acc_d = sum_c;
        ovf_d = ovf_q | ovf_c;
      end
      OUT: begin
        if (out_ready) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign mul_start = mul_start_q;
  assign out_valid = out_valid_q;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign out_acc   = acc_q;
`ifdef MAC_SAT_EN
  assign out_ovf   = ovf_q;
`else
  assign out_ovf   = 1'b0 & ovf_q;
`endif

endmodule

// File: tb/tb_booth_mac_ctrl.sv
// Self-checking bench for booth_mac_ctrl with a behavioural Booth multiplier and a dot-product reference.
module tb_booth_mac_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic [15:0] in_y = '0;
  logic        in_last = 1'b0;
  logic        mul_start;
  logic [15:0] mul_x, mul_y;
  logic        mul_busy;
  logic [31:0] mul_z;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [39:0] out_acc;
  logic        out_ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_mac_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last), .mul_start(mul_start),
    .mul_x(mul_x), .mul_y(mul_y), .mul_busy(mul_busy), .mul_z(mul_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf)
  );

  // Behavioural multiplier: random start gap and busy time, product valid once busy drops
  int phase, gap, blen;
  logic signed [15:0] cx, cy;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0; mul_busy <= 1'b0; mul_z <= '0; gap <= 0; blen <= 0; cx <= '0; cy <= '0;
    end else begin
      case (phase)
        0: if (mul_start) begin
             cx <= mul_x; cy <= mul_y;
             gap <= int'($urandom_range(0, 2)); blen <= int'($urandom_range(1, 5));
             phase <= 1;
           end
        1: if (gap == 0) begin
             mul_busy <= 1'b1; mul_z <= $urandom; phase <= 2;
           end else gap <= gap - 1;
        default: if (blen <= 1) begin
             mul_busy <= 1'b0; mul_z <= 32'(32'(cx) * 32'(cy)); phase <= 0;
           end else blen <= blen - 1;
      endcase
    end
  end

  // Reference dot product, arithmetic on 64-bit integers
  localparam longint TWO39 = 64'sd549755813888;
  longint ref_acc = 0;
  logic   ref_ovf = 1'b0;
  logic [15:0] last_x, last_y;

  task automatic ref_step(input logic signed [15:0] x, input logic signed [15:0] y);
    longint s;
    s = ref_acc + longint'(x) * longint'(y);
`ifdef MAC_SAT_EN
    if (s > TWO39 - 1) begin s = TWO39 - 1; ref_ovf = 1'b1; end
    else if (s < -TWO39) begin s = -TWO39; ref_ovf = 1'b1; end
`else
    s = s & (2 * TWO39 - 1);
    if (s >= TWO39) s = s - 2 * TWO39;
`endif
    ref_acc = s;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_pair(input logic signed [15:0] x, input logic signed [15:0] y, input logic last);
    int n = 0;
    @(negedge clk);
    in_x = x; in_y = y; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 500) begin @(negedge clk); n++; end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    last_x = x; last_y = y;
    ref_step(x, y);
  endtask

  task automatic get_result(input string name, input logic [39:0] exp_acc, input logic exp_ovf,
                            input int hold);
    int n = 0;
    while (!out_valid && n < 500) begin @(negedge clk); n++; end
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_acc"}, 64'(out_acc), 64'(exp_acc));
    chk({name, "_ovf"}, 64'(out_ovf), 64'(exp_ovf));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_x = 16'h7fff; in_y = 16'h7fff; in_last = 1'b0;
      @(negedge clk);
      chk({name, "_hold_acc"}, 64'(out_acc), 64'(exp_acc));
      chk({name, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({name, "_hold_inready"}, 64'(in_ready), 64'd0);
      chk({name, "_hold_mulx"}, 64'(mul_x), 64'(last_x));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_released"}, 64'(out_valid), 64'd0);
    ref_acc = 0; ref_ovf = 1'b0;
  endtask

  typedef struct {
    int          n;
    int          x[3];
    int          y[3];
    logic [39:0] exp_acc;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0].n = 1; tbl[0].x = '{3, 0, 0};      tbl[0].y = '{4, 0, 0};
    tbl[0].exp_acc = 40'd12;                  tbl[0].exp_ovf = 1'b0;
    tbl[1].n = 2; tbl[1].x = '{-5, 2, 0};     tbl[1].y = '{7, 3, 0};
    tbl[1].exp_acc = 40'hFF_FFFF_FFE3;        tbl[1].exp_ovf = 1'b0;
    tbl[2].n = 1; tbl[2].x = '{-32768, 0, 0}; tbl[2].y = '{-32768, 0, 0};
    tbl[2].exp_acc = 40'h00_4000_0000;        tbl[2].exp_ovf = 1'b0;
    tbl[3].n = 3; tbl[3].x = '{32767, 1, -2}; tbl[3].y = '{-32768, -1, -3};
    tbl[3].exp_acc = 40'(-64'sd1073709051);   tbl[3].exp_ovf = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_inready", 64'(in_ready), 64'd0);
    chk("rst_outvalid", 64'(out_valid), 64'd0);
    chk("rst_mulstart", 64'(mul_start), 64'd0);
    chk("rst_acc", 64'(out_acc), 64'd0);
    chk("rst_mulx", 64'({mul_x, mul_y}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_inready", 64'(in_ready), 64'd1);

    // Directed table
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < tbl[v].n; k++)
        send_pair(16'(tbl[v].x[k]), 16'(tbl[v].y[k]), k == tbl[v].n - 1);
      get_result($sformatf("tbl%0d", v), tbl[v].exp_acc, tbl[v].exp_ovf, 0);
    end

    // Stalled consumer, then the next product must start from zero
    send_pair(16'sd3, 16'sd4, 1'b1);
    get_result("hold", 40'd12, 1'b0, 5);
    send_pair(16'sd1, 16'sd2, 1'b1);
    get_result("after_hold", 40'd2, 1'b0, 0);

    // Accumulator range boundary
    for (int i = 0; i < 512; i++) send_pair(-16'sd32768, -16'sd32768, i == 511);
`ifdef MAC_SAT_EN
    get_result("sat512", 40'h7F_FFFF_FFFF, 1'b1, 0);
`else
    get_result("wrap512", 40'h80_0000_0000, 1'b0, 0);
`endif

    // Reset while the multiplier is busy discards the product
    send_pair(16'sd100, 16'sd200, 1'b0);
    send_pair(16'sd300, 16'sd200, 1'b1);
    begin
      int n = 0;
      while (!mul_busy && n < 50) begin @(negedge clk); n++; end
      chk("midrst_busy_seen", 64'(mul_busy), 64'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_acc", 64'(out_acc), 64'd0);
    chk("midrst_mulstart", 64'(mul_start), 64'd0);
    chk("midrst_inready", 64'(in_ready), 64'd0);
    chk("midrst_mulx", 64'({mul_x, mul_y}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_acc = 0; ref_ovf = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    send_pair(16'sd1, 16'sd1, 1'b1);
    get_result("midrst_pair", 40'd1, 1'b0, 0);

    // Random dot products against the reference
    for (int t = 0; t < 30; t++) begin
      int np = int'($urandom_range(1, 6));
      logic [39:0] e_acc;
      logic        e_ovf;
      for (int k = 0; k < np; k++) send_pair(16'($urandom), 16'($urandom), k == np - 1);
      e_acc = 40'(ref_acc);
      e_ovf = ref_ovf;
      get_result($sformatf("rand%0d", t), e_acc, e_ovf, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
